spram_rr_arbiter: RTL and testbench

- Shares one single-port RAM (1024 x 32, `spram` instance) between NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready command interface. Read data returns on a shared bus, tagged by a one-hot response-valid vector.
- Sits between accelerator front-ends (DSP chains, adder trees, systolic arrays) and the `spram` instance, which it drives directly.

---
 rtl/spram_arb_pkg.sv | 17 +
 rtl/spram_rr_arbiter_rr_grant.sv | 50 +++++
 rtl/spram_rr_arbiter.sv | 105 ++++++++++
 tb/tb_spram_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM round-robin arbiter.
package spram_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_IDX_W  = 3;

  function automatic int req_idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } rsp_tag_t;

endpackage

// File: rtl/spram_rr_arbiter_rr_grant.sv
// Combinational round-robin grant with a registered priority pointer.
module rr_grant
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_any && req[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spram_rr_arbiter.sv
// Shares one single-port RAM between NUM_REQ valid/ready requesters, round-robin,
// with in-order read responses tagged by a one-hot rsp_valid.
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RAM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wren,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         ram_address,
  output logic                      ram_wren,
  output logic [DATA_W-1:0]         ram_data,
  input  logic [DATA_W-1:0]         ram_out
);

  localparam int IDX_W = req_idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready is forced low while reset is held so nothing looks accepted.
  assign req_ready = reset ? '0 : grant;

  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;

  always_comb begin
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    if (grant_any) begin
      ram_address_d = req_addr[grant_idx*ADDR_W +: ADDR_W];
      ram_data_d    = req_wdata[grant_idx*DATA_W +: DATA_W];
      ram_wren_d    = req_wren[grant_idx];
    end
  end

  rsp_tag_t tag_q [RAM_LAT+1];
  rsp_tag_t tag_d [RAM_LAT+1];
  rsp_tag_t out_tag;

  always_comb begin
    tag_d[0].valid = grant_any & ~req_wren[grant_idx];
    tag_d[0].idx   = MAX_IDX_W'(grant_idx);
    for (int k = 1; k <= RAM_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  assign out_tag = tag_q[RAM_LAT];

  // Read data is taken from the RAM on the tag's valid cycle and held afterwards.
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d   = out_tag.valid ? ram_out : rdata_q;
    rsp_rdata = rdata_d;
    rsp_valid = out_tag.valid ? (NUM_REQ'(1) << out_tag.idx) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      rdata_q       <= '0;
      for (int k = 0; k <= RAM_LAT; k++) tag_q[k] <= '0;
    end else begin
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      rdata_q       <= rdata_d;
      for (int k = 0; k <= RAM_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Scoreboard bench for spram_rr_arbiter: directed scenarios plus random traffic
// against an acceptance-order reference model and a behavioural RAM.
module tb_spram_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_wren, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_data, ram_out;
  logic [AW-1:0]   ram_address;
  logic            ram_wren;

  spram_rr_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RAM_LAT (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wren    (req_wren),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ram_address (ram_address),
    .ram_wren    (ram_wren),
    .ram_data    (ram_data),
    .ram_out     (ram_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with LAT-cycle read latency.
  logic [DW-1:0] ram_mem [1024];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    rd_pipe[0] <= ram_mem[ram_address];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_out = rd_pipe[LAT-1];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Requester-side pending commands and the reference model state.
  logic          p_v [N];
  logic          p_w [N];
  logic [AW-1:0] p_a [N];
  logic [DW-1:0] p_d [N];
  int            ptr;
  logic [DW-1:0] mdl_mem [1024];
  logic          prev_acc, prev_w;
  logic [AW-1:0] prev_a, last_a;
  logic [DW-1:0] prev_d, last_d, last_rdata;

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_v[i] = 1'b1; p_w[i] = w; p_a[i] = a; p_d[i] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) p_v[i] = 1'b0;
    exp_q.delete();
    ptr = 0; prev_acc = 1'b0; last_a = '0; last_d = '0; last_rdata = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = p_v[i];
      req_wren[i]            = p_w[i];
      req_addr[i*AW +: AW]   = p_a[i];
      req_wdata[i*DW +: DW]  = p_d[i];
    end
  endtask

  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    drive();
    #1;
    if (prev_acc) begin
      check("ram_wren", ram_wren, prev_w);
      check("ram_address", ram_address, prev_a);
      check("ram_data", ram_data, prev_d);
    end else begin
      check("idle_wren", ram_wren, 0);
      check("idle_addr_hold", ram_address, last_a);
      check("idle_data_hold", ram_data, last_d);
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && p_v[(ptr + k) % N]) g = (ptr + k) % N;
    end
    exp_ready = (g < 0) ? '0 : (N'(1) << g);
    check("req_ready", req_ready, exp_ready);
    prev_acc = (g >= 0);
    if (g >= 0) begin
      prev_w = p_w[g]; prev_a = p_a[g]; prev_d = p_d[g];
      last_a = p_a[g]; last_d = p_d[g];
      if (p_w[g]) mdl_mem[p_a[g]] = p_d[g];
      else exp_q.push_back('{idx: g, data: mdl_mem[p_a[g]], due: cyc + 1 + LAT});
      ptr = (g + 1) % N;
      p_v[g] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_ram_address"}, ram_address, 0);
    check({tag, "_ram_wren"}, ram_wren, 0);
    check({tag, "_ram_data"}, ram_data, 0);
  endtask

  // Asserted mid-cycle, away from both edges, so the async path is what clears outputs.
  task automatic do_reset();
    @(negedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("rst");
    clear_model();
    @(negedge clk);
    drive();
    #3 reset = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_valid", rsp_valid, N'(1) << mon_e.idx);
          check("rsp_rdata", rsp_rdata, mon_e.data);
          check("rsp_cycle", cyc, mon_e.due);
          last_rdata = mon_e.data;
        end
      end else begin
        check("rsp_rdata_hold", rsp_rdata, last_rdata);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          check("rsp_missing", rsp_valid, N'(1) << exp_q[0].idx);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic rand_cycle();
    for (int i = 0; i < N; i++) begin
      if (p_v[i]) begin
        if ($urandom_range(9) == 0) p_v[i] = 1'b0;
      end else if ($urandom_range(1) == 1) begin
        set_cmd(i, $urandom_range(2) == 0,
                ($urandom_range(3) == 0) ? AW'(10'h3FF - $urandom_range(1)) : AW'($urandom_range(15)),
                $urandom());
      end
    end
    step();
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      ram_mem[a] = DW'(a) * 32'h9E3779B1 + 32'h1234;
      mdl_mem[a] = DW'(a) * 32'h9E3779B1 + 32'h1234;
    end
    for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;
    clear_model();
    reset = 1'b1;
    drive();
    #1 check_reset_outputs("init");
    @(negedge clk);
    #3 reset = 1'b0;

    // Single read after a preload write.
    set_cmd(0, 1'b1, 10'h005, 32'hDEADBEEF);
    step();
    set_cmd(2, 1'b0, 10'h005, 32'h0);
    step();
    idle(3);

    // Fairness: all requesters continuously valid with reads.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) if (!p_v[i]) set_cmd(i, 1'b0, AW'($urandom_range(31)), $urandom());
      step();
    end
    for (int i = 0; i < N; i++) p_v[i] = 1'b0;
    idle(3);

    // Skip idle requesters: pointer at 1, only 0 and 3 valid.
    set_cmd(0, 1'b0, 10'h010, 32'h0);
    step();
    set_cmd(0, 1'b0, 10'h011, 32'h0);
    set_cmd(3, 1'b0, 10'h012, 32'h0);
    step();
    step();
    set_cmd(0, 1'b0, 10'h013, 32'h0);
    set_cmd(1, 1'b0, 10'h014, 32'h0);
    step();
    step();
    idle(3);

    // Write then read of the top address.
    set_cmd(1, 1'b1, 10'h3FF, 32'h12345678);
    step();
    set_cmd(1, 1'b0, 10'h3FF, 32'h0);
    step();
    set_cmd(1, 1'b0, 10'h000, 32'h0);
    step();
    idle(3);

    // Withdrawal: requester 2 drops valid after losing to 0.
    do_reset();
    set_cmd(0, 1'b0, 10'h020, 32'h0);
    set_cmd(2, 1'b0, 10'h021, 32'h0);
    step();
    p_v[2] = 1'b0;
    idle(4);

    // Random traffic.
    for (int c = 0; c < 400; c++) rand_cycle();
    for (int i = 0; i < N; i++) p_v[i] = 1'b0;
    idle(4);

    // Reset one cycle after a read is accepted.
    set_cmd(1, 1'b0, 10'h030, 32'h0);
    step();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!p_v[i]) set_cmd(i, 1'b0, AW'($urandom_range(63)), $urandom());
      step();
    end
    for (int i = 0; i < N; i++) p_v[i] = 1'b0;
    idle(5);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
